// File: rtl/main_memory_arbiter_pkg.sv
// Shared types and configuration for the main-memory arbiter.
package main_memory_arbiter_pkg;

  // Main-memory bus geometry used as the default for every arbiter instance.
  localparam int CFG_ADDRESS_WIDTH = 32;
  localparam int CFG_DATA_WIDTH    = 32;

  // Default requester count and the matching id width.
  localparam int CFG_NUM_REQ  = 4;
  localparam int ARB_ID_WIDTH = $clog2(CFG_NUM_REQ);

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RELEASE = 2'd2
  } arb_state_t;

  // Id width for an arbitrary requester count (never narrower than one bit).
  function automatic int arb_id_width(input int num_req);
    return (num_req < 2) ? 1 : $clog2(num_req);
  endfunction

endpackage

// File: rtl/main_memory_arbiter_if.sv
// Requester and main-memory signal bundle of the arbiter.
//
// Handshake: a requester raises req_read/req_write (level) and holds it until
// it sees req_ready or req_error for its index. The arbiter holds
// main_memory_*_request, address and write data stable until main memory
// answers with main_memory_ready (read data valid in the same cycle).
interface main_memory_arbiter_if #(
  parameter int NUM_REQ                   = main_memory_arbiter_pkg::CFG_NUM_REQ,
  parameter int MAIN_MEMORY_ADDRESS_WIDTH = main_memory_arbiter_pkg::CFG_ADDRESS_WIDTH,
  parameter int MAIN_MEMORY_DATA_WIDTH    = main_memory_arbiter_pkg::CFG_DATA_WIDTH
);
  logic [NUM_REQ-1:0]                           req_read;
  logic [NUM_REQ-1:0]                           req_write;
  logic [NUM_REQ*MAIN_MEMORY_ADDRESS_WIDTH-1:0] req_address;
  logic [NUM_REQ*MAIN_MEMORY_DATA_WIDTH-1:0]    req_write_data;
  logic [NUM_REQ-1:0]                           req_grant;
  logic [NUM_REQ-1:0]                           req_ready;
  logic [NUM_REQ-1:0]                           req_error;
  logic [MAIN_MEMORY_DATA_WIDTH-1:0]            req_read_data;
  logic                                         main_memory_read_request;
  logic                                         main_memory_write_request;
  logic [MAIN_MEMORY_ADDRESS_WIDTH-1:0]         main_memory_address;
  logic [MAIN_MEMORY_DATA_WIDTH-1:0]            main_memory_write_data;
  logic [MAIN_MEMORY_DATA_WIDTH-1:0]            main_memory_read_data;
  logic                                         main_memory_ready;

  // Arbiter side: drives grants, responses and the memory strobes.
  modport master (
    input  req_read, req_write, req_address, req_write_data,
    input  main_memory_read_data, main_memory_ready,
    output req_grant, req_ready, req_error, req_read_data,
    output main_memory_read_request, main_memory_write_request,
    output main_memory_address, main_memory_write_data
  );

  // Environment side: requesters plus main memory.
  modport slave (
    output req_read, req_write, req_address, req_write_data,
    output main_memory_read_data, main_memory_ready,
    input  req_grant, req_ready, req_error, req_read_data,
    input  main_memory_read_request, main_memory_write_request,
    input  main_memory_address, main_memory_write_data
  );
endinterface

// File: rtl/main_memory_arbiter_rr_priority_picker.sv
// Combinational round-robin picker: first pending index after ptr, wrapping.
module main_memory_arbiter_rr_priority_picker #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] pending,
  input  logic [ID_W-1:0]    ptr,
  output logic [ID_W-1:0]    winner,
  output logic               valid
);

  // Walk from the farthest candidate back to ptr+1 so the nearest one wins.
  always_comb begin
    int               cand;
    logic [ID_W-1:0]  idx;
    winner = '0;
    valid  = |pending;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = (int'(ptr) + k) % NUM_REQ;
      idx  = ID_W'(cand);
      if (pending[idx]) winner = idx;
    end
  end

endmodule

// File: rtl/main_memory_arbiter.sv
// Round-robin arbiter sharing one main-memory port between NUM_REQ L3 FSMs.
module main_memory_arbiter
  import main_memory_arbiter_pkg::*;
#(
  parameter int NUM_REQ                   = CFG_NUM_REQ,
  parameter int TIMEOUT_CYCLES            = 1024,
  parameter int MAIN_MEMORY_ADDRESS_WIDTH = CFG_ADDRESS_WIDTH,
  parameter int MAIN_MEMORY_DATA_WIDTH    = CFG_DATA_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  main_memory_arbiter_if.master bus,
  output arb_state_t           dbg_state
);

  localparam int AW   = MAIN_MEMORY_ADDRESS_WIDTH;
  localparam int DW   = MAIN_MEMORY_DATA_WIDTH;
  localparam int ID_W = arb_id_width(NUM_REQ);
  // A zero timeout never fires; otherwise the last waiting cycle is count N-1.
  localparam bit          TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [31:0] TO_LAST = TO_EN ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;

  arb_state_t         state_q, state_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [31:0]        cnt_q, cnt_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] ready_q, ready_d;
  logic [NUM_REQ-1:0] error_q, error_d;
  logic [DW-1:0]      rdata_q, rdata_d;
  logic               rd_req_q, rd_req_d;
  logic               wr_req_q, wr_req_d;
  logic [AW-1:0]      addr_q, addr_d;
  logic [DW-1:0]      wdata_q, wdata_d;

  logic [AW-1:0]      addr_arr [NUM_REQ];
  logic [DW-1:0]      data_arr [NUM_REQ];
  logic [ID_W-1:0]    pick_id;
  logic               pick_valid;
  logic               timeout_hit;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
    assign addr_arr[g] = bus.req_address[g*AW +: AW];
    assign data_arr[g] = bus.req_write_data[g*DW +: DW];
  end

  main_memory_arbiter_rr_priority_picker #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_picker (
    .pending (bus.req_read | bus.req_write),
    .ptr     (ptr_q),
    .winner  (pick_id),
    .valid   (pick_valid)
  );

  assign timeout_hit = TO_EN && (cnt_q == TO_LAST);

  // Next-state and registered-output computation for the arbiter FSM.
  always_comb begin
    state_d  = state_q;
    id_d     = id_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    grant_d  = grant_q;
    ready_d  = '0;
    error_d  = '0;
    rdata_d  = rdata_q;
    rd_req_d = rd_req_q;
    wr_req_d = wr_req_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          // A write wins over a read from the same requester: writeback first.
          id_d             = pick_id;
          addr_d           = addr_arr[pick_id];
          wdata_d          = data_arr[pick_id];
          wr_req_d         = bus.req_write[pick_id];
          rd_req_d         = !bus.req_write[pick_id];
          grant_d          = '0;
          grant_d[pick_id] = 1'b1;
          cnt_d            = '0;
          state_d          = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.main_memory_ready) begin
          if (rd_req_q) rdata_d = bus.main_memory_read_data;
          rd_req_d       = 1'b0;
          wr_req_d       = 1'b0;
          ready_d[id_q]  = 1'b1;
          ptr_d          = id_q;
          state_d        = RELEASE;
        end else if (timeout_hit) begin
          rd_req_d       = 1'b0;
          wr_req_d       = 1'b0;
          error_d[id_q]  = 1'b1;
          ptr_d          = id_q;
          state_d        = RELEASE;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      RELEASE: begin
        // Dead cycle lets the owner drop its request before re-arbitration.
        grant_d = '0;
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset aborts any transaction silently.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      id_q     <= '0;
      ptr_q    <= ID_W'(NUM_REQ - 1);
      cnt_q    <= '0;
      grant_q  <= '0;
      ready_q  <= '0;
      error_q  <= '0;
      rdata_q  <= '0;
      rd_req_q <= 1'b0;
      wr_req_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      id_q     <= id_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      grant_q  <= grant_d;
      ready_q  <= ready_d;
      error_q  <= error_d;
      rdata_q  <= rdata_d;
      rd_req_q <= rd_req_d;
      wr_req_q <= wr_req_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
    end
  end

  assign bus.req_grant                 = grant_q;
  assign bus.req_ready                 = ready_q;
  assign bus.req_error                 = error_q;
  assign bus.req_read_data             = rdata_q;
  assign bus.main_memory_read_request  = rd_req_q;
  assign bus.main_memory_write_request = wr_req_q;
  assign bus.main_memory_address       = addr_q;
  assign bus.main_memory_write_data    = wdata_q;
  assign dbg_state                     = state_q;

endmodule

// File: tb/tb_main_memory_arbiter.sv
// Self-checking bench for main_memory_arbiter with a completion scoreboard.
module tb_main_memory_arbiter;
  import main_memory_arbiter_pkg::*;

  localparam int NR = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;
  // Completion record: {ready, error, write, id[2:0], addr[31:0], data[31:0]}
  localparam int RW = 70;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  arb_state_t dbg_state;

  main_memory_arbiter_if #(
    .NUM_REQ(NR), .MAIN_MEMORY_ADDRESS_WIDTH(AW), .MAIN_MEMORY_DATA_WIDTH(DW)
  ) mif ();

  main_memory_arbiter #(
    .NUM_REQ(NR), .TIMEOUT_CYCLES(TO),
    .MAIN_MEMORY_ADDRESS_WIDTH(AW), .MAIN_MEMORY_DATA_WIDTH(DW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (mif),
    .dbg_state (dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  int checks_total  = 0;
  int checks_passed = 0;
  logic [RW-1:0] exp_q[$];

  // Memory model state
  int          mem_lat;     // ready in this ISSUE cycle (1-based); 0 = never
  int          issue_cnt;
  int          last_len;
  bit          both_seen;
  logic [NR-1:0] cur_grant;
  logic [31:0] cur_addr;
  logic [31:0] cur_wdata;
  bit          cur_wr;

  function automatic logic [31:0] mem_model(input logic [31:0] a);
    return (a == 32'h40) ? 32'hDEAD_BEEF : (a ^ 32'hC0DE_0000);
  endfunction

  function automatic logic [RW-1:0] make_rec(input bit rdy, input bit err, input bit wr,
                                             input logic [2:0] id, input logic [31:0] a,
                                             input logic [31:0] d);
    return {rdy, err, wr, id, a, d};
  endfunction

  // Driver: one clock; then play main memory for the cycle that just began.
  task automatic tick();
    bit strobe;
    @(posedge clk);
    #1;
    strobe = mif.main_memory_read_request | mif.main_memory_write_request;
    if (mif.main_memory_read_request && mif.main_memory_write_request) both_seen = 1'b1;
    if (strobe) begin
      if (issue_cnt == 0) begin
        cur_grant = mif.req_grant;
        cur_addr  = mif.main_memory_address;
        cur_wdata = mif.main_memory_write_data;
        cur_wr    = mif.main_memory_write_request;
      end
      issue_cnt++;
    end else begin
      if (issue_cnt != 0) last_len = issue_cnt;
      issue_cnt = 0;
    end
    mif.main_memory_ready = strobe && (mem_lat != 0) && (issue_cnt == mem_lat);
    mif.main_memory_read_data = mif.main_memory_ready ? mem_model(mif.main_memory_address)
                                                      : $urandom;
  endtask

  task automatic set_req(input int i, input bit rd, input bit wr,
                         input logic [31:0] a, input logic [31:0] d);
    mif.req_read[i]             = rd;
    mif.req_write[i]            = wr;
    mif.req_address[i*AW +: AW] = a;
    mif.req_write_data[i*DW +: DW] = d;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    mif.req_read = '0;
    mif.req_write = '0;
    mif.req_address = '0;
    mif.req_write_data = '0;
    mif.main_memory_ready = 1'b0;
    mif.main_memory_read_data = '0;
    mem_lat = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    issue_cnt = 0;
    exp_q.delete();
  endtask

  // Monitor: wait for a ready/error pulse and build the observed record.
  task automatic wait_done(output logic [RW-1:0] obs, output bit ok, output int who);
    logic [NR-1:0] pulse;
    logic [2:0]    id;
    bit            rdy;
    ok = 1'b0;
    obs = '0;
    who = -1;
    for (int n = 0; n < 200; n++) begin
      tick();
      if (|mif.req_ready || |mif.req_error) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) return;
    pulse = mif.req_ready | mif.req_error;
    id = 3'd7;
    for (int i = 0; i < NR; i++)
      if (pulse[i] && $onehot(pulse) && pulse == cur_grant && pulse == mif.req_grant) begin
        id  = 3'(i);
        who = i;
      end
    rdy = |mif.req_ready;
    obs = make_rec(rdy, |mif.req_error, cur_wr, id, cur_addr,
                   rdy ? (cur_wr ? cur_wdata : mif.req_read_data) : 32'h0);
  endtask

  task automatic test_reset();
    do_reset();
    checks_total++;
    if ({mif.req_grant, mif.req_ready, mif.req_error, mif.req_read_data,
         mif.main_memory_read_request, mif.main_memory_write_request,
         mif.main_memory_address, mif.main_memory_write_data} !== '0)
      $display("FAIL reset_outputs: grant=%b rd=%b wr=%b addr=%h not all zero",
               mif.req_grant, mif.main_memory_read_request,
               mif.main_memory_write_request, mif.main_memory_address);
    else checks_passed++;
    checks_total++;
    if (dbg_state !== IDLE) $display("FAIL reset_state: got %0d expected %0d", dbg_state, IDLE);
    else checks_passed++;
    repeat (3) tick();
    checks_total++;
    if (mif.req_grant !== '0 || dbg_state !== IDLE)
      $display("FAIL idle_no_request: grant=%b state=%0d expected 0/IDLE", mif.req_grant, dbg_state);
    else checks_passed++;
  endtask

  task automatic test_single_read();
    logic [RW-1:0] obs, exp;
    bit ok;
    int who;
    do_reset();
    mem_lat = 3;
    set_req(2, 1, 0, 32'h40, 32'h0);
    exp_q.push_back(make_rec(1, 0, 0, 3'd2, 32'h40, 32'hDEAD_BEEF));
    tick();
    checks_total++;
    if (mif.main_memory_read_request !== 1'b1 || mif.req_grant !== 4'b0100)
      $display("FAIL read_latency: rd=%b grant=%b expected 1/0100",
               mif.main_memory_read_request, mif.req_grant);
    else checks_passed++;
    wait_done(obs, ok, who);
    set_req(2, 0, 0, 32'h0, 32'h0);
    exp = exp_q.pop_front();
    checks_total++;
    if (!ok || obs !== exp) $display("FAIL single_read: got %h expected %h ok=%0d", obs, exp, ok);
    else checks_passed++;
    checks_total++;
    if (last_len !== 3) $display("FAIL single_read_len: got %0d expected 3", last_len);
    else checks_passed++;
    tick();
    checks_total++;
    if (mif.req_grant !== '0 || mif.req_ready !== '0)
      $display("FAIL grant_clear: grant=%b ready=%b expected 0/0", mif.req_grant, mif.req_ready);
    else checks_passed++;
    tick();
    checks_total++;
    if (mif.req_grant !== '0 || mif.main_memory_read_request !== 1'b0)
      $display("FAIL no_stale_regrant: grant=%b rd=%b expected 0/0",
               mif.req_grant, mif.main_memory_read_request);
    else checks_passed++;
  endtask

  task automatic test_round_robin();
    logic [RW-1:0] obs, exp;
    bit ok;
    int who;
    int order[6] = '{0, 1, 3, 0, 1, 3};
    do_reset();
    mem_lat = 1;
    for (int i = 0; i < NR; i++)
      if (i != 2) set_req(i, 1, 0, 32'h100 + 32'(i) * 32'h10, 32'h0);
    foreach (order[k])
      exp_q.push_back(make_rec(1, 0, 0, 3'(order[k]), 32'h100 + 32'(order[k]) * 32'h10,
                               mem_model(32'h100 + 32'(order[k]) * 32'h10)));
    for (int k = 0; k < 6; k++) begin
      wait_done(obs, ok, who);
      if (k == 5) mif.req_read = '0;
      exp = exp_q.pop_front();
      checks_total++;
      if (!ok || obs !== exp) $display("FAIL rr_order[%0d]: got %h expected %h ok=%0d", k, obs, exp, ok);
      else checks_passed++;
    end
    repeat (3) tick();
  endtask

  task automatic test_write_before_read();
    logic [RW-1:0] obs, exp;
    bit ok;
    int who;
    do_reset();
    mem_lat = 2;
    set_req(1, 1, 1, 32'h80, 32'h1234);
    exp_q.push_back(make_rec(1, 0, 1, 3'd1, 32'h80, 32'h1234));
    exp_q.push_back(make_rec(1, 0, 0, 3'd1, 32'h80, mem_model(32'h80)));
    for (int k = 0; k < 2; k++) begin
      wait_done(obs, ok, who);
      if (k == 0) mif.req_write[1] = 1'b0;
      else mif.req_read[1] = 1'b0;
      exp = exp_q.pop_front();
      checks_total++;
      if (!ok || obs !== exp) $display("FAIL write_first[%0d]: got %h expected %h ok=%0d", k, obs, exp, ok);
      else checks_passed++;
    end
    repeat (3) tick();
  endtask

  task automatic test_timeout();
    logic [RW-1:0] obs, exp;
    bit ok;
    int who;
    do_reset();
    mem_lat = 0;
    set_req(0, 1, 0, 32'h200, 32'h0);
    set_req(2, 1, 0, 32'h220, 32'h0);
    exp_q.push_back(make_rec(0, 1, 0, 3'd0, 32'h200, 32'h0));
    exp_q.push_back(make_rec(1, 0, 0, 3'd2, 32'h220, mem_model(32'h220)));
    for (int k = 0; k < 2; k++) begin
      wait_done(obs, ok, who);
      if (who >= 0) mif.req_read[who] = 1'b0;
      if (k == 0) begin
        checks_total++;
        if (last_len !== TO) $display("FAIL timeout_len: got %0d expected %0d", last_len, TO);
        else checks_passed++;
        mem_lat = 2;
      end
      exp = exp_q.pop_front();
      checks_total++;
      if (!ok || obs !== exp) $display("FAIL timeout[%0d]: got %h expected %h ok=%0d", k, obs, exp, ok);
      else checks_passed++;
    end
    repeat (3) tick();
  endtask

  task automatic test_ready_at_timeout();
    logic [RW-1:0] obs, exp;
    bit ok;
    int who;
    do_reset();
    mem_lat = TO;
    set_req(3, 1, 0, 32'h3C0, 32'h0);
    exp_q.push_back(make_rec(1, 0, 0, 3'd3, 32'h3C0, mem_model(32'h3C0)));
    wait_done(obs, ok, who);
    mif.req_read[3] = 1'b0;
    exp = exp_q.pop_front();
    checks_total++;
    if (!ok || obs !== exp) $display("FAIL ready_wins: got %h expected %h ok=%0d", obs, exp, ok);
    else checks_passed++;
    checks_total++;
    if (last_len !== TO) $display("FAIL ready_wins_len: got %0d expected %0d", last_len, TO);
    else checks_passed++;
    repeat (3) tick();
  endtask

  task automatic test_reset_mid_issue();
    logic [RW-1:0] obs, exp;
    bit ok;
    int who;
    do_reset();
    mem_lat = 0;
    set_req(1, 0, 1, 32'h300, 32'h77);
    repeat (3) tick();
    #2 reset = 1'b1;
    #1;
    checks_total++;
    if ({mif.req_grant, mif.req_ready, mif.req_error, mif.req_read_data,
         mif.main_memory_read_request, mif.main_memory_write_request,
         mif.main_memory_address, mif.main_memory_write_data} !== '0 || dbg_state !== IDLE)
      $display("FAIL async_reset: grant=%b wr=%b addr=%h state=%0d expected all 0/IDLE",
               mif.req_grant, mif.main_memory_write_request, mif.main_memory_address, dbg_state);
    else checks_passed++;
    set_req(0, 1, 0, 32'h310, 32'h0);
    mem_lat = 1;
    @(posedge clk);
    #1 reset = 1'b0;
    issue_cnt = 0;
    exp_q.push_back(make_rec(1, 0, 0, 3'd0, 32'h310, mem_model(32'h310)));
    exp_q.push_back(make_rec(1, 0, 1, 3'd1, 32'h300, 32'h77));
    for (int k = 0; k < 2; k++) begin
      wait_done(obs, ok, who);
      if (who >= 0) set_req(who, 0, 0, 32'h0, 32'h0);
      exp = exp_q.pop_front();
      checks_total++;
      if (!ok || obs !== exp) $display("FAIL after_reset[%0d]: got %h expected %h ok=%0d", k, obs, exp, ok);
      else checks_passed++;
    end
    repeat (3) tick();
    checks_total++;
    if (both_seen !== 1'b0) $display("FAIL strobe_exclusive: both strobes seen=%0d expected 0", both_seen);
    else checks_passed++;
  endtask

  initial begin
    both_seen = 1'b0;
    issue_cnt = 0;
    last_len  = 0;
    test_reset();
    test_single_read();
    test_round_robin();
    test_write_before_read();
    test_timeout();
    test_ready_at_timeout();
    test_reset_mid_issue();
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
